axi_req_tx_arbiter: RTL

// Downstream consumer of the AXI slave request path. Arbitrates between the

---
 rtl/axi_req_tx_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/axi_req_tx_arbiter.sv
// Arbitrates the AXI slave's pending write and read requests onto the TL TX stream.
// Credits are checked once per TLP in IDLE; a TLP, once started, runs to completion.
module axi_req_tx_arbiter #(
    parameter int HDR_W     = 128,
    parameter int DATA_W    = 256,
    parameter int PD_CRED_W = 12,
    parameter int HCRED_W   = 8
) (
    input  logic                 axi_clk,
    input  logic                 ARESTn,
    input  logic                 axi_wrreq_hdr_valid,
    input  logic [HDR_W-1:0]     axi_wrreq_hdr,
    input  logic [9:0]           axi_wrreq_len,
    input  logic [DATA_W-1:0]    axi_req_data,
    input  logic                 axi_rdreq_hdr_valid,
    input  logic [HDR_W-1:0]     axi_rdreq_hdr,
    output logic                 axi_req_wr_grant,
    output logic                 axi_req_rd_grant,
    input  logic [HCRED_W-1:0]   fc_ph_avail,
    input  logic [PD_CRED_W-1:0] fc_pd_avail,
    input  logic [HCRED_W-1:0]   fc_nph_avail,
    output logic                 fc_ph_consume,
    output logic                 fc_pd_consume,
    output logic [8:0]           fc_pd_amount,
    output logic                 fc_nph_consume,
    output logic                 tlp_valid,
    input  logic                 tlp_ready,
    output logic                 tlp_sop,
    output logic                 tlp_eop,
    output logic [DATA_W-1:0]    tlp_data
);

    localparam int DW_PER_BEAT = DATA_W / 32;
    localparam int LEN_W       = 11;

    typedef enum logic [1:0] {S_IDLE, S_RD_HDR, S_WR_HDR, S_WR_DATA} state_t;

    function automatic logic [LEN_W-1:0] f_len_eff(input logic [9:0] len);
        return (len == 10'd0) ? LEN_W'(1024) : {1'b0, len};
    endfunction

    // One posted-data credit covers 4 DW, rounded up.
    function automatic logic [8:0] f_pd_credits(input logic [LEN_W-1:0] len_eff);
        logic [LEN_W:0] sum;
        sum = {1'b0, len_eff} + (LEN_W+1)'(3);
        return sum[LEN_W-1:2];
    endfunction

    function automatic logic [LEN_W-1:0] f_beats(input logic [LEN_W-1:0] len_eff);
        logic [LEN_W:0] sum;
        sum = {1'b0, len_eff} + (LEN_W+1)'(DW_PER_BEAT - 1);
        return LEN_W'(sum / (LEN_W+1)'(DW_PER_BEAT));
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rr_last_wr;
    logic [LEN_W-1:0] r_beat_cnt;
    logic [LEN_W-1:0] r_len_eff;
    logic [LEN_W-1:0] r_beats;

    logic [LEN_W-1:0] w_len_eff;
    logic [8:0]       w_pd_need;
    logic             w_wr_ok;
    logic             w_rd_ok;
    logic             w_pick_wr;
    logic             w_last_beat;

    assign w_len_eff   = f_len_eff(axi_wrreq_len);
    assign w_pd_need   = f_pd_credits(w_len_eff);
    assign w_wr_ok     = axi_wrreq_hdr_valid && (fc_ph_avail != '0) &&
                         (32'(fc_pd_avail) >= 32'(w_pd_need));
    assign w_rd_ok     = axi_rdreq_hdr_valid && (fc_nph_avail != '0);
    assign w_pick_wr   = w_wr_ok && (!w_rd_ok || !r_rr_last_wr);
    assign w_last_beat = (r_beat_cnt == LEN_W'(1));

    always_ff @(posedge axi_clk or negedge ARESTn) begin
        if (!ARESTn) begin
            r_state      <= S_IDLE;
            r_rr_last_wr <= 1'b0;
            r_beat_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_RD_HDR: if (tlp_ready) r_rr_last_wr <= 1'b0;
                S_WR_HDR: if (tlp_ready) r_beat_cnt <= r_beats;
                S_WR_DATA: begin
                    if (tlp_ready) begin
                        r_beat_cnt <= r_beat_cnt - LEN_W'(1);
                        if (w_last_beat) r_rr_last_wr <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Length is tracked every IDLE cycle so the value at the decision edge is kept.
    always_ff @(posedge axi_clk) begin
        if (r_state == S_IDLE) begin
            r_len_eff <= w_len_eff;
            r_beats   <= f_beats(w_len_eff);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        tlp_valid        = 1'b0;
        tlp_sop          = 1'b0;
        tlp_eop          = 1'b0;
        tlp_data         = '0;
        axi_req_wr_grant = 1'b0;
        axi_req_rd_grant = 1'b0;
        fc_ph_consume    = 1'b0;
        fc_pd_consume    = 1'b0;
        fc_pd_amount     = '0;
        fc_nph_consume   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr_ok || w_rd_ok)
                    w_state_nxt = w_pick_wr ? S_WR_HDR : S_RD_HDR;
            end
            S_RD_HDR: begin
                tlp_valid = 1'b1;
                tlp_sop   = 1'b1;
                tlp_eop   = 1'b1;
                tlp_data  = DATA_W'(axi_rdreq_hdr);
                if (tlp_ready) begin
                    axi_req_rd_grant = 1'b1;
                    fc_nph_consume   = 1'b1;
                    w_state_nxt      = S_IDLE;
                end
            end
            S_WR_HDR: begin
                tlp_valid = 1'b1;
                tlp_sop   = 1'b1;
                tlp_data  = DATA_W'(axi_wrreq_hdr);
                if (tlp_ready) begin
                    axi_req_wr_grant = 1'b1;
                    fc_ph_consume    = 1'b1;
                    fc_pd_consume    = 1'b1;
                    fc_pd_amount     = f_pd_credits(r_len_eff);
                    w_state_nxt      = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                tlp_valid = 1'b1;
                tlp_eop   = w_last_beat;
                tlp_data  = axi_req_data;
                if (tlp_ready) begin
                    axi_req_wr_grant = 1'b1;
                    if (w_last_beat) w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
